// File: rtl/piso_sched_pkg.sv
// rtl/piso_sched_pkg.sv - shared types and width helpers for the PISO load scheduler
package piso_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Counter/index width for a range of n values; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_GAP_CYC = 1;

    localparam int DEF_BIT_CNT_W = cnt_w(DEF_DATA_W);
    localparam int DEF_GAP_CNT_W = cnt_w(DEF_GAP_CYC);
    localparam int DEF_IDX_W     = cnt_w(DEF_NUM_REQ);

endpackage

// File: rtl/piso_rr_arbiter.sv
// rtl/piso_rr_arbiter.sv - combinational round-robin grant over NUM_REQ requesters
// Ports: req (request vector), ptr (highest-priority index),
//        grant (one-hot, zero when no request), grant_idx (index of grant).
module piso_rr_arbiter
    import piso_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = cnt_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    localparam int SUM_W = IDX_W + 1;

    logic [NUM_REQ-1:0] rot;
    logic [SUM_W-1:0]   sum;

    // Rotate the request vector so that bit 0 is the pointer position, find the
    // lowest set bit, then map the offset back to an absolute index.
    always_comb begin
        rot       = NUM_REQ'({req, req} >> ptr);
        sum       = '0;
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sum = {1'b0, ptr} + SUM_W'(i);
            end
        end
        if (|req) begin
            if (sum >= SUM_W'(NUM_REQ)) begin
                grant_idx = IDX_W'(sum - SUM_W'(NUM_REQ));
            end else begin
                grant_idx = IDX_W'(sum);
            end
            grant = NUM_REQ'(1) << grant_idx;
        end
    end

endmodule

// File: rtl/piso_load_sched.sv
// rtl/piso_load_sched.sv - round-robin scheduler sharing one PISO shifter between requesters
// Optional feature macro: PISO_SCHED_PARITY_EN (adds ser_parity and a parity slot after bit 0).
// Ports: clk, rst (async, active-low); req_valid/req_data/req_ready (requester side,
//        requester i at req_data[i*DATA_W +: DATA_W]); piso_load/piso_data (PISO pins);
//        ser_valid (PISO output carries a valid bit); grant_id (owner of current word);
//        busy (not IDLE); done (one-hot pulse on the owner's last serial slot).
module piso_load_sched
    import piso_sched_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NUM_REQ = 2,
    parameter int GAP_CYC = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        piso_load,
    output logic [DATA_W-1:0]           piso_data,
    output logic                        ser_valid,
    output logic [cnt_w(NUM_REQ)-1:0]   grant_id,
    output logic                        busy,
    output logic [NUM_REQ-1:0]          done
`ifdef PISO_SCHED_PARITY_EN
    ,
    output logic                        ser_parity
`endif
);

    localparam int IDX_W    = cnt_w(NUM_REQ);
    localparam int CNT_W    = cnt_w(DATA_W);
    localparam int GAP_W    = cnt_w(GAP_CYC);
    localparam int GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  word_q;
    logic [IDX_W-1:0]   gid_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [DATA_W-1:0]  sel_word;
    logic               accept;
    logic               last_slot;
`ifdef PISO_SCHED_PARITY_EN
    logic               par_slot;
`endif

    piso_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_word = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        piso_load = 1'b0;
        ser_valid = 1'b0;
        done      = '0;
        accept    = 1'b0;
        last_slot = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                // req_ready is combinational from req_valid; gating with rst keeps
                // every output low while reset is held.
                req_ready = arb_grant & {NUM_REQ{rst}};
                if (|arb_grant) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                piso_load = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                ser_valid = 1'b1;
`ifdef PISO_SCHED_PARITY_EN
                last_slot = par_slot;
`else
                last_slot = (bit_cnt == '0);
`endif
                if (last_slot) begin
                    done      = NUM_REQ'(1) << gid_q;
                    state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: held word, owner, RR pointer and the shift/gap timers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q  <= '0;
            gid_q   <= '0;
            ptr_q   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (accept) begin
                word_q <= sel_word;
                gid_q  <= arb_idx;
                ptr_q  <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
            end
            if (state == LOAD) begin
                bit_cnt <= CNT_W'(DATA_W - 1);
            end else if (state == SHIFT && bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
            if (last_slot) begin
                gap_cnt <= GAP_W'(GAP_LOAD);
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

`ifdef PISO_SCHED_PARITY_EN
    // One extra SHIFT slot after bit 0 carries the XOR of the held word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_slot <= 1'b0;
        end else if (last_slot) begin
            par_slot <= 1'b0;
        end else if (state == SHIFT && bit_cnt == '0) begin
            par_slot <= 1'b1;
        end
    end

    assign ser_parity = (state == SHIFT && par_slot) ? ^word_q : 1'b0;
`endif

    assign piso_data = word_q;
    assign grant_id  = gid_q;

endmodule

// File: tb/tb_piso_load_sched.sv
// tb/tb_piso_load_sched.sv - scoreboard bench for piso_load_sched
module tb_piso_load_sched;

    localparam int DATA_W  = 8;
    localparam int GAP_CYC = 1;
`ifdef PISO_SCHED_PARITY_EN
    localparam int SER_LEN = DATA_W + 1;
`else
    localparam int SER_LEN = DATA_W;
`endif
    localparam int PER  = 2 + SER_LEN + GAP_CYC;
    localparam int PER0 = 2 + SER_LEN;

    typedef struct {
        int         id;
        logic [7:0] word;
        int         period;
        logic       par;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid, req_valid0;
    logic [15:0] req_data, req_data0;
    logic [1:0]  req_ready, req_ready0;
    logic        piso_load, piso_load0;
    logic [7:0]  piso_data, piso_data0;
    logic        ser_valid, ser_valid0;
    logic        grant_id, grant_id0;
    logic        busy, busy0;
    logic [1:0]  done, done0;
`ifdef PISO_SCHED_PARITY_EN
    logic        ser_parity, ser_parity0;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   dn0 = 0;
    int   runs0 = 0;
    exp_t exp_q[$];
    int   q0[$];
    logic [7:0] sr;
    logic       piso_out;

    piso_load_sched #(.DATA_W(DATA_W), .NUM_REQ(2), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .piso_load(piso_load), .piso_data(piso_data),
        .ser_valid(ser_valid), .grant_id(grant_id), .busy(busy), .done(done)
`ifdef PISO_SCHED_PARITY_EN
        , .ser_parity(ser_parity)
`endif
    );

    piso_load_sched #(.DATA_W(DATA_W), .NUM_REQ(2), .GAP_CYC(0)) dut0 (
        .clk(clk), .rst(rst_n), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .piso_load(piso_load0), .piso_data(piso_data0),
        .ser_valid(ser_valid0), .grant_id(grant_id0), .busy(busy0), .done(done0)
`ifdef PISO_SCHED_PARITY_EN
        , .ser_parity(ser_parity0)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External PISO model: parallel load, MSB shifted out first.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)         sr <= '0;
        else if (piso_load) sr <= piso_data;
        else                sr <= sr << 1;
    end
    assign piso_out = sr[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Main monitor: pops the scoreboard on each accept, checks load, serial bits and done.
    initial begin
        exp_t cur;
        bit   cur_v = 1'b0;
        int   bitn = 0;
        int   last_acc = -1;
        int   load_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur_v = 1'b0; bitn = 0; last_acc = -1;
                continue;
            end
            if (|(req_valid & req_ready)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", req_ready, 0);
                end else begin
                    cur = exp_q.pop_front();
                    cur_v = 1'b1; bitn = 0;
                    chk("accept_onehot", req_ready, 1 << cur.id);
                    if (cur.period > 0) chk("accept_period", cyc - last_acc, cur.period);
                    last_acc = cyc;
                end
            end
            if (piso_load) begin
                if (!cur_v) chk("load_without_accept", 1, 0);
                else begin
                    chk("load_data", piso_data, cur.word);
                    chk("load_grant_id", grant_id, cur.id);
                    chk("load_latency", cyc - last_acc, 1);
                    load_cyc = cyc;
                end
            end
            if (ser_valid) begin
                if (!cur_v) chk("stray_ser_valid", 1, 0);
                else begin
                    bitn++;
                    chk("ser_contiguous", cyc - load_cyc, bitn);
                    if (bitn <= DATA_W) chk("ser_bit", piso_out, cur.word[DATA_W-bitn]);
`ifdef PISO_SCHED_PARITY_EN
                    else chk("ser_parity", ser_parity, cur.par);
`endif
                end
            end
`ifdef PISO_SCHED_PARITY_EN
            if (!(ser_valid && bitn > DATA_W)) chk("parity_idle_zero", ser_parity, 0);
`endif
            if (done != 0) begin
                if (!cur_v) chk("done_without_word", done, 0);
                else begin
                    chk("done_vec", done, 1 << cur.id);
                    chk("done_slot", bitn, SER_LEN);
                    done_seen++;
                    cur_v = 1'b0;
                end
            end
        end
    end

    // GAP_CYC=0 monitor: accept spacing and length of ser_valid low runs between words.
    initial begin
        int  prev0 = -1;
        int  run = 0;
        bit  seen_high = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev0 = -1; run = 0; seen_high = 1'b0;
                continue;
            end
            if (|(req_valid0 & req_ready0)) begin
                if (prev0 >= 0 && q0.size() > 0) chk("gap0_period", cyc - prev0, q0.pop_front());
                prev0 = cyc;
            end
            if (ser_valid0) begin
                if (seen_high && run > 0) begin
                    chk("gap0_low_run", run, 2);
                    runs0++;
                end
                run = 0;
                seen_high = 1'b1;
            end else if (seen_high) begin
                run++;
            end
            if (done0 != 0) begin
                chk("gap0_done_vec", done0, 2'b10);
                dn0++;
            end
        end
    end

    task automatic sample_at(input int x);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (cyc < x && k < 1000);
    endtask

    task automatic wait_acc(input int idx, output int t);
        bit got = 1'b0;
        t = cyc;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (req_valid[idx] && req_ready[idx]) begin
                got = 1'b1;
                t = cyc;
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_any(output int t);
        bit got = 1'b0;
        t = cyc;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (|(req_valid & req_ready)) begin
                got = 1'b1;
                t = cyc;
            end
        end
        if (!got) chk("any_accept_timeout", 0, 1);
    endtask

    task automatic wait_acc0(output int t);
        bit got = 1'b0;
        t = cyc;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (req_valid0[1] && req_ready0[1]) begin
                got = 1'b1;
                t = cyc;
            end
        end
        if (!got) chk("gap0_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || busy0) && k < 200);
        if (k >= 200) chk("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t, t2;
        rst_n = 1'b0;
        req_valid = '0; req_data = '0;
        req_valid0 = '0; req_data0 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {req_ready, piso_load, piso_data, ser_valid, grant_id, busy, done}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_no_ready", {req_ready, busy}, 0);

        // Single word A5 from requester 0, then 07 (odd parity) from requester 1.
        exp_q.push_back('{id:0, word:8'hA5, period:0, par:1'b0});
        @(posedge clk); #1 req_data[7:0] = 8'hA5; req_valid[0] = 1'b1;
        wait_acc(0, t);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        sample_at(t + PER - 1);
        chk("busy_last_cycle", busy, 1);
        sample_at(t + PER);
        chk("busy_dropped", busy, 0);
        exp_q.push_back('{id:1, word:8'h07, period:0, par:1'b1});
        @(posedge clk); #1 req_data[15:8] = 8'h07; req_valid[1] = 1'b1;
        wait_acc(1, t);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_idle();

        // Late valid: requester 1 rises during requester 0's SHIFT.
        exp_q.push_back('{id:0, word:8'h5A, period:0, par:1'b0});
        exp_q.push_back('{id:1, word:8'h96, period:PER, par:1'b0});
        @(posedge clk); #1 req_data[7:0] = 8'h5A; req_valid[0] = 1'b1;
        wait_acc(0, t);
        @(posedge clk); #1 req_valid[0] = 1'b0;
        sample_at(t + 4);
        req_data[15:8] = 8'h96; req_valid[1] = 1'b1;
        sample_at(t + 6);
        chk("late_ready_shift", req_ready, 0);
        sample_at(t + PER - 1);
        chk("late_ready_gap", req_ready, 0);
        wait_acc(1, t2);
        chk("late_grant_cycle", t2 - t, PER);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        wait_idle();

        // Reset mid-SHIFT: word 81 is discarded, no done pulse.
        exp_q.push_back('{id:1, word:8'h81, period:0, par:1'b0});
        @(posedge clk); #1 req_data[15:8] = 8'h81; req_valid[1] = 1'b1;
        wait_acc(1, t);
        @(posedge clk); #1 req_valid[1] = 1'b0;
        sample_at(t + 5);
        rst_n = 1'b0;
        #1;
        chk("reset_mid_outputs", {req_ready, piso_load, piso_data, ser_valid, grant_id, busy, done}, 0);
        exp_q.delete();
        req_data = 16'hC33C; req_valid = 2'b11;
        @(negedge clk);
        chk("reset_ready_gated", req_ready, 0);

        // Contention after release: 0,1,0,1 at one word period each.
        exp_q.push_back('{id:0, word:8'h3C, period:0, par:1'b0});
        exp_q.push_back('{id:1, word:8'hC3, period:PER, par:1'b0});
        exp_q.push_back('{id:0, word:8'h3C, period:PER, par:1'b0});
        exp_q.push_back('{id:1, word:8'hC3, period:PER, par:1'b0});
        @(posedge clk); #1 rst_n = 1'b1;
        for (int n = 0; n < 4; n++) wait_any(t);
        @(posedge clk); #1 req_valid = 2'b00;
        wait_idle();

        // GAP_CYC=0 instance: requester 1 held for three words.
        q0.push_back(PER0);
        q0.push_back(PER0);
        @(posedge clk); #1 req_data0[15:8] = 8'h5A; req_valid0 = 2'b10;
        wait_acc0(t);
        wait_acc0(t2);
        chk("gap0_second_accept", t2 - t, PER0);
        wait_acc0(t2);
        chk("gap0_third_accept", t2 - t, 2 * PER0);
        @(posedge clk); #1 req_valid0 = 2'b00;
        wait_idle();

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("done_count", done_seen, 8);
        chk("gap0_queue_empty", q0.size(), 0);
        chk("gap0_runs", runs0, 2);
        chk("gap0_dones", dn0, 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_load_sched.md
Name: piso_load_sched

Overview:
- Scheduler that shares one PISO shifter between NUM_REQ parallel-word requesters.
- Arbitrates round-robin and accepts one word per grant.
- Drives the PISO load and data_in pins, then times the DATA_W shift cycles and signals completion to the granted requester.
- Sits between the requester-side logic and the piso instance in the hardware top.

Parameters:
- DATA_W, 8: PISO word width; number of shift cycles per word.
- NUM_REQ, 2: number of requesters (2..8).
- GAP_CYC, 1: idle cycles inserted after each word before the next grant (0..15).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester word available.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- piso_load  out  1  to PISO load.
- piso_data  out  DATA_W  to PISO data_in.
- ser_valid  out  1  high while PISO data_out carries a valid bit.
- grant_id  out  $clog2(NUM_REQ)  index of the requester owning the current word.
- busy  out  1  high in every state except IDLE.
- done  out  NUM_REQ  one-cycle pulse on the last serial bit of the owner's word.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; RR pointer 0 (requester 0 highest priority); held word cleared. Any in-flight word is discarded and no done pulse is generated.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - req_ready is combinational: one-hot grant of the first valid requester searching upward from the RR pointer, with wrap.
  - Handshake completes on req_valid[i] & req_ready[i]. On that cycle (T) the word is captured, grant_id is set to i, the RR pointer becomes (i+1) mod NUM_REQ, and the next state is LOAD.
  - With no valid requester, stay in IDLE and hold req_ready=0.
- LOAD (cycle T+1): piso_load=1, piso_data=held word; next state SHIFT. piso_data holds the word until the next accept (it is not cleared). piso_load is 1 only in LOAD.
- SHIFT (cycles T+2 .. T+1+DATA_W):
  - ser_valid=1.
  - bit counter (width $clog2(DATA_W)) runs down from DATA_W-1 to 0.
  - When the counter is 0, done[grant_id]=1 and the next state is GAP, or IDLE if GAP_CYC=0.
- GAP: ser_valid=0; counts GAP_CYC cycles, then IDLE.
- req_ready is 0 outside IDLE. Requesters must hold req_valid and req_data stable until accepted.
- Changes on req_valid or req_data outside IDLE have no effect on the word in flight.
- grant_id is stable from T+1 until the next accept.
- Per-word period: 2+DATA_W+GAP_CYC cycles.
- Simultaneous valids: exactly one grant per IDLE visit. Fairness guarantees each continuously-valid requester a grant within NUM_REQ words.

Optional Feature:
- PISO_SCHED_PARITY_EN.
- Defined:
  - SHIFT is extended by one extra slot after bit 0; ser_valid stays 1 during the slot.
  - New output ser_parity (1 bit) carries the even parity (XOR) of the held word during that slot and is 0 otherwise.
  - done moves to the parity slot.
  - Period becomes 3+DATA_W+GAP_CYC.
- Undefined: there is no ser_parity port and no extra slot.

Decomposition:
- Package piso_sched_pkg:
  - state enum (IDLE, LOAD, SHIFT, GAP).
  - localparam width helpers for the bit counter, gap counter and grant index.
- Sub-module piso_rr_arbiter: combinational NUM_REQ round-robin grant, inputs req vector and pointer, outputs one-hot grant and index. The pointer register remains in piso_load_sched.

Test Plan:
- Single word: req_valid[0]=1, req_data=8'hA5 (defaults) -> req_ready[0] at T; piso_load=1 with piso_data=8'hA5 at T+1; ser_valid T+2..T+9 and PISO data_out equals 1,0,1,0,0,1,0,1; done[0] at T+9; busy drops at T+11.
- Contention: req_valid=2'b11, words 8'h3C and 8'hC3, both held -> grants in order 0,1,0,1; each word period is 11 cycles; grant_id follows 0,1,0,1.
- Back-to-back, GAP_CYC=0, req_valid[1] held -> accepts at T, T+10, T+20; ser_valid has exactly one low gap of 2 cycles (IDLE+LOAD) between words.
- Reset mid-SHIFT: rst=0 at T+5 -> all outputs 0 immediately and no done pulse. After release with req_valid[1]=1 and req_valid[0]=1, requester 0 is granted first.
- Late valid: req_valid[1] rises during SHIFT of requester 0's word -> req_ready[1] stays 0 until IDLE, then req_ready[1] is granted.
- Parity (PISO_SCHED_PARITY_EN): word 8'hA5 -> ser_valid T+2..T+10, ser_parity=0 at T+10, done at T+10. Word 8'h07 -> ser_parity=1.
